// File: rtl/key_pkg.sv
// Shared types, defaults and row-decoding helpers for the keypad scanner.
package key_pkg;

  localparam int SCAN_DIV_DEF     = 50000;
  localparam int DEBOUNCE_CNT_DEF = 4;

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } key_state_e;

  // Closed contacts on one row (low bits), saturated at 2.
  function automatic logic [1:0] contact_cnt(input logic [3:0] col_n);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      n = n + {2'b00, ~col_n[i]};
    end
    contact_cnt = (n >= 3'd2) ? 2'd2 : n[1:0];
  endfunction

  // Column index of a single low bit; only meaningful when exactly one is low.
  function automatic logic [1:0] low_col(input logic [3:0] col_n);
    case (col_n)
      4'b1110: low_col = 2'd0;
      4'b1101: low_col = 2'd1;
      4'b1011: low_col = 2'd2;
      4'b0111: low_col = 2'd3;
      default: low_col = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for an asynchronous bus; resets to the idle (all-ones) level.
module sync2 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // Metastability stage followed by the settled output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= {W{1'b1}};
      sync_q <= {W{1'b1}};
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/key_scan.sv
// 4x4 matrix keypad scanner: free-running row drive, per-scan single-contact
// detection, and a debounce FSM producing key_code / key_valid / key_down.
module key_scan
  import key_pkg::*;
#(
  parameter int SCAN_DIV     = SCAN_DIV_DEF,
  parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int            DW       = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0]    DB_CNT   = 4'(DEBOUNCE_CNT);

  logic [3:0]    col_s;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    row_q, row_d;
  logic [3:0]    row_n_q, row_n_d;
  logic [1:0]    hits_q, hits_d;
  logic [3:0]    acc_code_q, acc_code_d;
  logic          sample_s, boundary_s, scan_hit_s, match_s;
  logic [1:0]    row_hits_s;
  logic [2:0]    hit_sum_s;
  logic [3:0]    scan_code_s;

  key_state_e    state_q, state_d;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_down_q, key_down_d;

  sync2 #(.W(4)) u_col_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (col_n),
    .q_o   (col_s)
  );

  // Row divider, row rotation and per-scan contact accumulation.
  always_comb begin
    sample_s   = (div_q == DIV_LAST);
    boundary_s = sample_s && (row_q == 2'd3);
    row_hits_s = contact_cnt(col_s);
    hit_sum_s  = {1'b0, hits_q} + {1'b0, row_hits_s};
    if ((hits_q == 2'd0) && (row_hits_s == 2'd1)) begin
      scan_code_s = {row_q, low_col(col_s)};
    end else begin
      scan_code_s = acc_code_q;
    end
    scan_hit_s = boundary_s && (hit_sum_s == 3'd1);
    match_s    = scan_hit_s && (scan_code_s == cand_q);

    div_d      = sample_s ? DW'(0) : div_q + DW'(1);
    row_d      = row_q;
    row_n_d    = row_n_q;
    hits_d     = hits_q;
    acc_code_d = acc_code_q;
    if (sample_s) begin
      row_d   = row_q + 2'd1;
      row_n_d = {row_n_q[2:0], row_n_q[3]};
      if (boundary_s) begin
        hits_d     = 2'd0;
        acc_code_d = 4'd0;
      end else begin
        hits_d     = (hit_sum_s >= 3'd2) ? 2'd2 : hit_sum_s[1:0];
        acc_code_d = scan_code_s;
      end
    end else begin
      hits_d = hits_q;
    end
  end

  // Debounce FSM next-state and registered-output logic; moves only at scan boundaries.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    if (boundary_s) begin
      case (state_q)
        ST_RELEASED: begin
          if (scan_hit_s) begin
            cand_d = scan_code_s;
            if (DB_CNT == 4'd1) begin
              state_d     = ST_PRESSED;
              key_code_d  = scan_code_s;
              key_valid_d = 1'b1;
              cnt_d       = 4'd0;
            end else begin
              state_d = ST_PRESS_WAIT;
              cnt_d   = 4'd1;
            end
          end else begin
            cnt_d = 4'd0;
          end
        end
        ST_PRESS_WAIT: begin
          if (match_s) begin
            if ((cnt_q + 4'd1) == DB_CNT) begin
              state_d     = ST_PRESSED;
              key_code_d  = cand_q;
              key_valid_d = 1'b1;
              cnt_d       = 4'd0;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            state_d = ST_RELEASED;
            cnt_d   = 4'd0;
          end
        end
        ST_PRESSED: begin
          if (match_s) begin
            state_d = ST_PRESSED;
          end else if (DB_CNT == 4'd1) begin
            state_d = ST_RELEASED;
            cnt_d   = 4'd0;
          end else begin
            state_d = ST_RELEASE_WAIT;
            cnt_d   = 4'd1;
          end
        end
        ST_RELEASE_WAIT: begin
          if (match_s) begin
            state_d = ST_PRESSED;
            cnt_d   = 4'd0;
          end else if ((cnt_q + 4'd1) == DB_CNT) begin
            state_d = ST_RELEASED;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        default: begin
          state_d = ST_RELEASED;
          cnt_d   = 4'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    key_down_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_WAIT);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q       <= DW'(0);
      row_q       <= 2'd0;
      row_n_q     <= 4'b1110;
      hits_q      <= 2'd0;
      acc_code_q  <= 4'd0;
      state_q     <= ST_RELEASED;
      cand_q      <= 4'd0;
      cnt_q       <= 4'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
    end else begin
      div_q       <= div_d;
      row_q       <= row_d;
      row_n_q     <= row_n_d;
      hits_q      <= hits_d;
      acc_code_q  <= acc_code_d;
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
    end
  end

  assign row_n     = row_n_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;

endmodule

// File: tb/tb_key_scan.sv
// Directed bench for key_scan with a behavioural 4x4 keypad driven by a key mask.
module tb_key_scan;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 3;
  localparam int SCAN_CYC     = 16;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;
  logic [15:0] keys = 16'h0000;

  int vectors     = 0;
  int miscompares = 0;
  int pulses      = 0;

  always #5 clk = ~clk;

  key_scan #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .col_n     (col_n),
    .row_n     (row_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_down  (key_down)
  );

  // A held key at (r,c) pulls column c low while row r is driven low.
  always_comb begin
    col_n = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!row_n[r] && keys[r*4+c]) col_n[c] = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (key_valid === 1'b1) pulses++;
  endtask

  task automatic run_scans(input int n);
    repeat (n * SCAN_CYC) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    keys  = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_row_n", 32'(row_n), 32'hE);
    check("rst_code", 32'(key_code), 32'h0);
    check("rst_valid", 32'(key_valid), 32'h0);
    check("rst_down", 32'(key_down), 32'h0);

    // Scan 0, idle keypad: row order and period.
    rst_n = 1'b1;
    repeat (4) tick();
    check("row1", 32'(row_n), 32'hD);
    repeat (4) tick();
    check("row2", 32'(row_n), 32'hB);
    repeat (4) tick();
    check("row3", 32'(row_n), 32'h7);
    repeat (4) tick();
    check("row0_wrap", 32'(row_n), 32'hE);

    // Key 9 bouncing: present, absent, present -> nothing accepted.
    pulses = 0;
    keys = 16'h0200; run_scans(1);
    keys = 16'h0000; run_scans(1);
    keys = 16'h0200; run_scans(1);
    keys = 16'h0000; run_scans(1);
    check("bounce_pulses", 32'(pulses), 32'd0);
    check("bounce_code", 32'(key_code), 32'h0);
    check("bounce_down", 32'(key_down), 32'h0);

    // Key 9 held: accepted at the third boundary, exactly one pulse.
    pulses = 0;
    keys = 16'h0200;
    run_scans(1);
    check("hold9_s1_down", 32'(key_down), 32'h0);
    run_scans(1);
    check("hold9_s2_pulses", 32'(pulses), 32'd0);
    run_scans(1);
    check("hold9_valid", 32'(key_valid), 32'h1);
    check("hold9_code", 32'(key_code), 32'h9);
    check("hold9_down", 32'(key_down), 32'h1);
    tick();
    check("hold9_valid_1cyc", 32'(key_valid), 32'h0);
    repeat (3 * SCAN_CYC - 1) tick();
    check("hold9_pulses", 32'(pulses), 32'd1);
    check("hold9_down_held", 32'(key_down), 32'h1);

    // Release with one bounce scan restarting the release count.
    keys = 16'h0000; run_scans(1);
    check("rel_s1_down", 32'(key_down), 32'h1);
    run_scans(1);
    check("rel_s2_down", 32'(key_down), 32'h1);
    keys = 16'h0200; run_scans(1);
    check("rel_bounce_down", 32'(key_down), 32'h1);
    keys = 16'h0000; run_scans(2);
    check("rel_s2b_down", 32'(key_down), 32'h1);
    run_scans(1);
    check("rel_done_down", 32'(key_down), 32'h0);
    check("rel_pulses", 32'(pulses), 32'd1);
    check("rel_code_held", 32'(key_code), 32'h9);

    // Keys 5 and 10 together are rejected; releasing 10 accepts 5.
    pulses = 0;
    keys = 16'h0420; run_scans(6);
    check("dual_pulses", 32'(pulses), 32'd0);
    check("dual_down", 32'(key_down), 32'h0);
    check("dual_code", 32'(key_code), 32'h9);
    keys = 16'h0020; run_scans(2);
    check("k5_s2_pulses", 32'(pulses), 32'd0);
    run_scans(1);
    check("k5_valid", 32'(key_valid), 32'h1);
    check("k5_code", 32'(key_code), 32'h5);
    check("k5_pulses", 32'(pulses), 32'd1);
    keys = 16'h0000; run_scans(3);
    check("k5_rel_down", 32'(key_down), 32'h0);

    // Reset in the middle of a press debounce, then a full new press.
    pulses = 0;
    keys = 16'h0200; run_scans(2);
    repeat (5) tick();
    check("pre_rst_pulses", 32'(pulses), 32'd0);
    check("pre_rst_row", 32'(row_n), 32'hD);
    rst_n = 1'b0;
    #1;
    check("mid_rst_row", 32'(row_n), 32'hE);
    check("mid_rst_code", 32'(key_code), 32'h0);
    check("mid_rst_valid", 32'(key_valid), 32'h0);
    check("mid_rst_down", 32'(key_down), 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_scans(2);
    check("post_rst_s2_pulses", 32'(pulses), 32'd0);
    check("post_rst_s2_down", 32'(key_down), 32'h0);
    run_scans(1);
    check("post_rst_valid", 32'(key_valid), 32'h1);
    check("post_rst_code", 32'(key_code), 32'h9);
    check("post_rst_pulses", 32'(pulses), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/key_scan.md
KEY_SCAN -- requirements
Module: key_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000; clk cycles each keypad row is driven (1 ms at 50 MHz); legal minimum 4.
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 4; consecutive identical full-scan results needed to accept a press or a release; legal range 1..15.
REQ-003 SHALL have port clk, input, 1; the single clock for all logic.
REQ-004 SHALL have port rst_n, input, 1; asynchronous, active-low reset.
REQ-005 SHALL have port col_n, input, 4; keypad columns, pulled up, low = contact; asynchronous to clk.
REQ-006 SHALL have port row_n, output, 4; keypad row drive, active-low one-hot.
REQ-007 SHALL have port key_code, output, 4; code of the last accepted key, = row*4 + col; feeds the 7-segment ROM address.
REQ-008 SHALL have port key_valid, output, 1; one-cycle pulse when a new press is accepted.
REQ-009 SHALL have port key_down, output, 1; level, high while the accepted key is held.

Function
REQ-010 SHALL pass col_n through a 2-flop synchronizer before any use.
REQ-011 SHALL drive row_n in the order 1110, 1101, 1011, 0111, then repeat; each pattern is held exactly SCAN_DIV cycles; the scan is free-running.
REQ-012 SHALL sample the synchronized columns in the last cycle of each row period.
REQ-013 SHALL report a column index as the position of its low bit: col_n[0] = col 0, col_n[3] = col 3.
REQ-014 SHALL define a scan boundary as the last cycle of the row-3 period; the result of a full scan is "hit + code" only if exactly one contact was seen over all 4 rows; otherwise the result is "no hit".
REQ-015 SHALL treat two or more contacts anywhere in one scan as "no hit".
REQ-016 SHALL use a debounce FSM that updates only at scan boundaries; its states are RELEASED, PRESS_WAIT, PRESSED and RELEASE_WAIT; it keeps a candidate code and a counter.
REQ-017 SHALL, in RELEASED on a hit: set cand = code, cnt = 1, and go to PRESS_WAIT; if DEBOUNCE_CNT == 1, accept immediately instead (go straight to PRESSED).
REQ-018 SHALL, in PRESS_WAIT on a hit with code == cand: increment cnt; when cnt reaches DEBOUNCE_CNT, accept.
REQ-019 SHALL, in PRESS_WAIT on "no hit" or a different code: return to RELEASED with cnt = 0, and accept nothing.
REQ-020 SHALL, on accept: go to PRESSED, load key_code <= cand, and pulse key_valid high in the cycle following the boundary, for exactly 1 cycle.
REQ-021 SHALL, in PRESSED on a hit with code == cand: stay in PRESSED; on anything else: go to RELEASE_WAIT with cnt = 1 (or straight to RELEASED if DEBOUNCE_CNT == 1).
REQ-022 SHALL, in RELEASE_WAIT: count consecutive non-matching results and go to RELEASED at DEBOUNCE_CNT; a matching hit returns to PRESSED with no new key_valid.
REQ-023 SHALL assert key_down in PRESSED and RELEASE_WAIT, registered and updated with the FSM.
REQ-024 SHALL hold key_code after release until the next accepted press.
REQ-025 SHALL fire key_valid at most once per press; holding a key never repeats it.
REQ-026 SHALL size the divider width as clog2(SCAN_DIV) and wrap it to 0 after SCAN_DIV-1.

Reset
REQ-027 SHALL, while rst_n is low, asynchronously force: row_n = 1110, key_code = 0, key_valid = 0, key_down = 0, FSM = RELEASED, counters = 0, synchronizer = 1111.
REQ-028 SHALL, on reset mid-debounce or mid-press, discard all progress and produce no key_valid until a full new DEBOUNCE_CNT sequence completes.

Structure
REQ-029 SHALL place the FSM state enum and the default SCAN_DIV/DEBOUNCE_CNT constants in shared package key_pkg.
REQ-030 SHALL place the 2-flop synchronizer in sub-module sync2, instantiated once for the 4-bit column bus.

Verification
REQ-031 SHALL run the bench with SCAN_DIV = 4 and DEBOUNCE_CNT = 3; one full scan is 16 cycles.
REQ-032 SHALL cover: hold the row 2 / col 1 contact -> exactly one key_valid pulse, key_code = 9, at 3 scan boundaries after first detection; key_down stays high while held.
REQ-033 SHALL cover: key 9 present for 1 scan, absent for 1, present for 1 -> no key_valid, key_code stays 0.
REQ-034 SHALL cover: keys 5 and 10 pressed together for 6 scans -> no key_valid, key_down = 0; release 10 -> key_valid with key_code = 5 after 3 scans.
REQ-035 SHALL cover: release after accept -> key_down falls at the 3rd boundary without contact; 1 scan of bounce contact restarts the release count and produces no new pulse.
REQ-036 SHALL cover: rst_n pulsed low during PRESS_WAIT -> row_n = 1110 and all outputs 0 immediately; a full 3-scan press is required afterwards.
